ro_scan_counter: RTL
====================

Name: ro_scan_counter

Overview:
- Drives the 4-bit select of the 16:1 ring-oscillator output mux and measures the selected oscillator's frequency.
- On start, steps the select through channels 0..15. For each channel it waits a settle window, then counts rising edges of the muxed output over a programmable gate window, and stores the count.
- Results are read back through a simple registered read port for the wishbone/LA glue.

Parameters:
- CH, 16, number of mux channels; the select width is fixed at 4, so CH must be at most 16
- CNT_W, 16, width of each edge count
- GATE_W, 16, width of the gate-cycle setting
- SETTLE, 8, clock cycles waited after each select change before counting starts (must be at least 3)

Ports:
- wb_clk_i  in  1  system clock; the only clock in the block
- wb_rst_n  in  1  asynchronous, active-low reset
- start_i  in  1  starts a full scan; sampled only in IDLE
- gate_cycles_i  in  GATE_W  count window length in clocks; captured on start
- ro_i  in  1  muxed ring-oscillator output; asynchronous to wb_clk_i
- sel_o  out  4  select to the mux
- busy_o  out  1  high while a scan is running
- done_o  out  1  one-cycle pulse when the scan completes
- ovf_o  out  CH  per-channel flag: the count saturated
- rd_addr_i  in  4  result channel to read
- rd_data_o  out  CNT_W  stored count for rd_addr_i, registered

Behaviour:
- Reset (asynchronous assert, synchronous release via flops): all outputs 0, sel_o=0, state IDLE, all result words and ovf_o cleared.
- Input path: ro_i passes through a 2-flop synchronizer, then a rising-edge detect (edge = s2 & ~s2_d).
  - The sync and edge flops run in every state.
  - Edges are counted only in COUNT.
  - Valid for f_ro < f_clk/2.
- States: IDLE, SETTLE, COUNT, STORE, DONE.
- IDLE:
  - start_i=1 captures G = gate_cycles_i; G=0 is treated as 1.
  - Sets ch=0, sel_o=0, busy_o=1, and clears the settle timer.
  - Next state SETTLE.
- SETTLE:
  - Waits exactly SETTLE cycles, then goes to COUNT with edge counter=0 and gate timer=0.
- COUNT:
  - Stays exactly G cycles.
  - Each cycle with edge=1 increments the count.
  - At the maximum value (2^CNT_W - 1) the count holds and sets the ovf flag for that channel.
  - After G cycles, next state STORE.
- STORE (1 cycle):
  - Writes the count into result[ch] and ovf_o[ch].
  - If ch == CH-1, next state DONE.
  - Otherwise ch++, sel_o updates to the new channel in the same cycle, and next state SETTLE.
- DONE (1 cycle):
  - done_o=1, busy_o=0, sel_o returns to 0, next state IDLE.
  - busy_o falls in the same cycle done_o pulses.
- Per-channel latency: SETTLE + G + 1 clocks.
- Full scan: CH*(SETTLE+G+1) + 1 clocks from the start cycle to the done_o cycle.
- start_i while not in IDLE is ignored; no queueing or restart.
- gate_cycles_i changes mid-scan have no effect; G is fixed per scan.
- Read port: rd_data_o <= result[rd_addr_i] on every clock, so read latency is 1 cycle.
  - Reading the channel being written in STORE returns the old value that cycle and the new value the next cycle.
- Results persist between scans; each scan overwrites all CH entries.
- Reset mid-scan: immediate return to IDLE, all outputs cleared, and no done_o pulse.

Decomposition:
- Package ro_scan_pkg holds:
  - the state enum (IDLE, SETTLE, COUNT, STORE, DONE)
  - the default constants for CH, CNT_W, GATE_W and SETTLE
  - a function returning the full scan length
- One sub-module, ro_edge_sync: 2-flop synchronizer plus rising-edge detect, clocked by wb_clk_i and reset by wb_rst_n, with output edge_o.
- The result array lives in the top block as registers; no SRAM macro.

Test Plan:
- Reset check: wb_rst_n=0 at any point -> sel_o=0, busy_o=0, done_o=0, ovf_o=0, rd_data_o=0 for every address one cycle after release.
- Basic scan: SETTLE=8, G=100, ro_i driven synchronously with period 4 clocks on every channel.
  - Expected: sel_o steps 0..15, each held 109 cycles.
  - done_o pulses 1745 cycles after start.
  - Every result reads 25 and ovf_o=0.
- Per-channel distinct input: ro_i period = 2*(ch+1) clocks, keyed on sel_o, with G=240 -> result[ch] = 120/(ch+1) (ch0=120, ch1=60, ch2=40, ch15=7 after truncation).
- Saturation: CNT_W=4, G=100, period 4 -> every result=15 and ovf_o=16'hFFFF; the next scan with period 16 gives result=6 and clears ovf_o.
- Boundary and ignore cases:
  - gate_cycles_i=0 gives a 1-cycle window, with a result of 0 or 1 matching the edge position.
  - start_i pulsed while busy_o=1 does not extend or restart the scan; done_o pulses once.
- Reset mid-scan: assert wb_rst_n=0 during channel 5 COUNT.
  - Expected: no done_o pulse; results read 0.
  - A new start then completes a normal full scan.

Source files
------------

// File: rtl/ro_scan_pkg.sv
// Shared types and default constants for the ring-oscillator scan counter.
// The scan-length helper gives software and benches one place to get the full-scan duration.
package ro_scan_pkg;

  localparam int CH_DEF     = 16;
  localparam int CNT_W_DEF  = 16;
  localparam int GATE_W_DEF = 16;
  localparam int SETTLE_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_COUNT,
    S_STORE,
    S_DONE
  } state_t;

  // Clocks from the start cycle to the done_o cycle; a zero gate setting behaves as one.
  function automatic int scan_cycles(int ch, int settle, int gate);
    int g;
    g = (gate == 0) ? 1 : gate;
    return ch * (settle + g + 1) + 1;
  endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Brings the asynchronous ring-oscillator output into the wb_clk_i domain
// and flags each rising edge for one clock.
module ro_edge_sync (
  input  logic wb_clk_i,
  input  logic wb_rst_n,
  input  logic ro_i,
  output logic edge_o
);

  logic s1;
  logic s2;
  logic s2_d;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, which is what makes this a real 2-flop chain.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
    end else begin
      s1   <= ro_i;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  assign edge_o = s2 & ~s2_d;

endmodule

// File: rtl/ro_scan_counter.sv
// Steps the 16:1 ring-oscillator mux through every channel, counts synchronized
// rising edges over a programmable gate window and keeps one result word per channel.
module ro_scan_counter
  import ro_scan_pkg::*;
#(
  parameter int CH     = CH_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int GATE_W = GATE_W_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              start_i,
  input  logic [GATE_W-1:0] gate_cycles_i,
  input  logic              ro_i,
  output logic [3:0]        sel_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CH-1:0]     ovf_o,
  input  logic [3:0]        rd_addr_i,
  output logic [CNT_W-1:0]  rd_data_o
);

  // SETTLE is at least 3, so this timer is always at least 2 bits wide.
  localparam int             SET_W   = $clog2(SETTLE);
  localparam logic [3:0]     LAST_CH = 4'(CH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              state;
  logic [GATE_W-1:0]   gate_len;
  logic [GATE_W-1:0]   gate_cnt;
  logic [SET_W-1:0]    settle_cnt;
  logic [CNT_W-1:0]    cnt;
  logic                sat;
  logic                ro_edge;
  logic [CNT_W-1:0]    result [CH];

  ro_edge_sync u_edge_sync (
    .wb_clk_i (wb_clk_i),
    .wb_rst_n (wb_rst_n),
    .ro_i     (ro_i),
    .edge_o   (ro_edge)
  );

  // sel_o doubles as the channel index; it only ever holds 0..CH-1.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state      <= S_IDLE;
      sel_o      <= 4'd0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      ovf_o      <= '0;
      gate_len   <= '0;
      gate_cnt   <= '0;
      settle_cnt <= '0;
      cnt        <= '0;
      sat        <= 1'b0;
      // NOTE: the result words are plain flops, so they are cleared by reset
      // like any other state; an SRAM here could not be reset this way.
      for (int i = 0; i < CH; i++) begin
        result[i] <= '0;
      end
    end else begin
      done_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            gate_len   <= (gate_cycles_i == '0) ? GATE_W'(1) : gate_cycles_i;
            sel_o      <= 4'd0;
            busy_o     <= 1'b1;
            settle_cnt <= '0;
            state      <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (settle_cnt == SET_W'(SETTLE - 1)) begin
            cnt      <= '0;
            sat      <= 1'b0;
            gate_cnt <= '0;
            state    <= S_COUNT;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end

        S_COUNT: begin
          if (ro_edge) begin
            if (cnt == CNT_MAX) begin
              sat <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          if (gate_cnt == gate_len - GATE_W'(1)) begin
            state <= S_STORE;
          end else begin
            gate_cnt <= gate_cnt + GATE_W'(1);
          end
        end

        S_STORE: begin
          result[sel_o] <= cnt;
          ovf_o[sel_o]  <= sat;
          if (sel_o == LAST_CH) begin
            sel_o  <= 4'd0;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= S_DONE;
          end else begin
            sel_o      <= sel_o + 4'd1;
            settle_cnt <= '0;
            state      <= S_SETTLE;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Registered read port; a STORE to the addressed word shows up one clock later.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      rd_data_o <= '0;
    end else if (int'(rd_addr_i) < CH) begin
      rd_data_o <= result[rd_addr_i];
    end else begin
      rd_data_o <= '0;
    end
  end

endmodule
